lisnoc_router_vc_scheduler: RTL

LISNOC_ROUTER_VC_SCHEDULER -- requirements
Module: lisnoc_router_vc_scheduler

---
 rtl/lisnoc_router_vc_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lisnoc_router_vc_scheduler.sv
// Weighted round-robin virtual-channel scheduler for one physical output link.
//
// Each VC gets up to quota flits per turn (a quota of 0 counts as 1). The VC
// at the pointer keeps priority while eligible; otherwise the next eligible VC
// in rotating order wins in the same cycle, so the link never idles while any
// VC is eligible.
//
// Optional feature: define LISNOC_VC_SCHED_PKT_LOCK_EN for packet-atomic
// scheduling (a HEADER locks the link to its VC until LAST/SINGLE, and turn
// expiry is deferred to a packet boundary).
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   fifo_valid_i  per-VC head flit available
//   fifo_flit_i   per-VC head flits, VC v at [(v+1)*flit_width-1 : v*flit_width]
//   fifo_ready_o  per-VC pop strobe (one-hot or zero)
//   quota_i       per-VC weight, quota_width bits each
//   link_valid_o  one-hot VC of link_flit_o, or zero
//   link_flit_o   flit driven to the link (zero when idle)
//   link_ready_i  per-VC downstream acceptance
module lisnoc_router_vc_scheduler #(
    parameter int unsigned vchannels       = 2,
    parameter int unsigned flit_data_width = 32,
    parameter int unsigned flit_type_width = 2,
    parameter int unsigned quota_width     = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [vchannels-1:0]                                 fifo_valid_i,
    input  logic [(flit_data_width+flit_type_width)*vchannels-1:0] fifo_flit_i,
    output logic [vchannels-1:0]                                 fifo_ready_o,
    input  logic [quota_width*vchannels-1:0]                     quota_i,
    output logic [vchannels-1:0]                                 link_valid_o,
    output logic [flit_data_width+flit_type_width-1:0]           link_flit_o,
    input  logic [vchannels-1:0]                                 link_ready_i
);

    localparam int unsigned flit_width = flit_data_width + flit_type_width;
    localparam int unsigned ptr_width  = (vchannels > 1) ? $clog2(vchannels) : 1;

    logic [ptr_width-1:0]   cur_q, cur_d;
    logic [quota_width-1:0] cnt_q, cnt_d;
    logic [quota_width:0]   cnt_inc;
    logic [vchannels-1:0]   eligible;
    logic                   sel_valid;
    logic [ptr_width-1:0]   sel;
    logic [flit_width-1:0]  sel_flit;
    logic [quota_width-1:0] eff_quota [vchannels];
    logic                   lock_only;

    function automatic logic [ptr_width-1:0] wrap_inc(input logic [ptr_width-1:0] p);
        if (int'(p) >= int'(vchannels) - 1) return '0;
        return p + ptr_width'(1);
    endfunction

`ifdef LISNOC_VC_SCHED_PKT_LOCK_EN
    logic                       lock_q, lock_d;
    logic [flit_type_width-1:0] sel_type;
    logic                       is_header, is_tail;

    assign lock_only = lock_q;
    assign sel_type  = sel_flit[flit_width-1 -: flit_type_width];
    assign is_header = (sel_type == flit_type_width'(1));
    assign is_tail   = (sel_type == flit_type_width'(2)) || (sel_type == flit_type_width'(3));
`else
    assign lock_only = 1'b0;
`endif

    assign eligible = fifo_valid_i & link_ready_i;
    assign cnt_inc  = {1'b0, cnt_q} + (quota_width + 1)'(1);

    always_comb begin
        for (int v = 0; v < int'(vchannels); v++) begin
            eff_quota[v] = quota_i[v*quota_width +: quota_width];
            if (eff_quota[v] == '0) eff_quota[v] = quota_width'(1);
        end
    end

    // Rotating priority starting at cur; a held lock restricts the search to cur.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel_valid = 1'b0;
        sel       = '0;
        if (lock_only) begin
            sel_valid = eligible[cur_q];
            sel       = cur_q;
        end else begin
            for (int unsigned i = 0; i < vchannels; i++) begin
                idx = int'(cur_q) + i;
                if (idx >= vchannels) idx = idx - vchannels;
                if (!sel_valid && eligible[idx]) begin
                    sel_valid = 1'b1;
                    sel       = ptr_width'(idx);
                end
            end
        end
    end

    always_comb begin
        sel_flit     = fifo_flit_i[int'(sel)*flit_width +: flit_width];
        link_valid_o = '0;
        fifo_ready_o = '0;
        link_flit_o  = '0;
        if (sel_valid) begin
            link_valid_o = vchannels'(1) << sel;
            fifo_ready_o = vchannels'(1) << sel;
            link_flit_o  = sel_flit;
        end
    end

    always_comb begin
        cur_d = cur_q;
        cnt_d = cnt_q;
`ifdef LISNOC_VC_SCHED_PKT_LOCK_EN
        lock_d = lock_q;
        if (sel_valid) begin
            if (is_header) lock_d = 1'b1;
            else if (is_tail) lock_d = 1'b0;
            if (sel == cur_q) begin
                // Turn may only end at a packet boundary; count saturates meanwhile.
                if (is_tail && (cnt_inc >= {1'b0, eff_quota[cur_q]})) begin
                    cur_d = wrap_inc(cur_q);
                    cnt_d = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + quota_width'(1);
                end
            end else if (is_tail && (eff_quota[sel] == quota_width'(1))) begin
                cur_d = wrap_inc(sel);
                cnt_d = '0;
            end else begin
                cur_d = sel;
                cnt_d = quota_width'(1);
            end
        end
`else
        if (sel_valid) begin
            if (sel == cur_q) begin
                if (cnt_inc == {1'b0, eff_quota[cur_q]}) begin
                    cur_d = wrap_inc(cur_q);
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + quota_width'(1);
                end
            end else if (eff_quota[sel] == quota_width'(1)) begin
                cur_d = wrap_inc(sel);
                cnt_d = '0;
            end else begin
                cur_d = sel;
                cnt_d = quota_width'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q <= '0;
            cnt_q <= '0;
        end else begin
            cur_q <= cur_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef LISNOC_VC_SCHED_PKT_LOCK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lock_q <= 1'b0;
        else      lock_q <= lock_d;
    end
`endif

endmodule
